clk_div_ctrl: RTL and testbench

//  Sequencer for the count-based clock divider (sel 0:/2, 1:/4, 2:/8, 3:off).

---
 rtl/clk_div_pkg.sv | 30 +++
 rtl/clk_div_ctrl.sv | 120 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and phase helper for the clock-divider sequencer.
package clk_div_pkg;

  // Divide ratio encoding seen by the divider.
  typedef enum logic [1:0] {
    DIV2    = 2'd0,
    DIV4    = 2'd1,
    DIV8    = 2'd2,
    DIV_OFF = 2'd3
  } div_sel_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    HOLD   = 3'd3,
    ALIGN  = 3'd4,
    FIN    = 3'd5
  } ctrl_state_t;

  // Low count bits that are all ones one edge before every divided output falls.
  localparam logic [2:0] PH_MASK = 3'b111;

  // True when the divider sits on the safe phase point.
  function automatic logic at_phase(input logic [2:0] cnt);
    return (cnt & PH_MASK) == PH_MASK;
  endfunction

endpackage

// File: rtl/clk_div_ctrl.sv
// Glitch-free divide-ratio sequencer: gate at a safe phase, switch, hold,
// re-align on the next phase point, then ungate. Owns div_sel and div_gate.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int DEFAULT_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,        // async, active low
  input  logic             req_valid,
  input  logic [1:0]       req_sel,
  output logic             req_ready,
  input  logic [CNT_W-1:0] div_count,
  output logic [1:0]       div_sel,
  output logic             div_gate,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cur_sel
);

  localparam logic [1:0] DEF_SEL   = 2'(DEFAULT_SEL);
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  ctrl_state_t state;
  div_sel_t    nsel;
  logic [3:0]  hold_cnt;
  logic        ph;

  // Only the low three count bits carry phase; upper bits just wrap.
  assign ph = at_phase(div_count[2:0]);

  if (CNT_W > 3) begin : g_cnt_hi
    logic unused_cnt_hi;
    assign unused_cnt_hi = ^div_count[CNT_W-1:3];
  end

  // Sequencer FSM; every output is a register so the divider sees clean levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ALIGN;
      nsel      <= div_sel_t'(DEF_SEL);
      div_sel   <= DEF_SEL;
      div_gate  <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      cur_sel   <= DEF_SEL;
      hold_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            nsel      <= div_sel_t'(req_sel);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            // Already gated (off): no phase to wait for before switching.
            state     <= div_gate ? DRAIN : SWITCH;
          end
        end
        DRAIN: begin
          if (ph) begin
            // All divided outputs fall on this edge, so gating here cuts no pulse.
            div_gate <= 1'b0;
            div_sel  <= nsel;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end
        end
        SWITCH: begin
          div_sel  <= nsel;
          hold_cnt <= HOLD_INIT;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            if (nsel == DIV_OFF) begin
              // Nothing to re-align when the clock stays off.
              done    <= 1'b1;
              cur_sel <= nsel;
              state   <= FIN;
            end else begin
              state <= ALIGN;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        ALIGN: begin
          if (ph) begin
            // Ungate as the new ratio starts a fresh low phase.
            div_gate <= (nsel != DIV_OFF);
            done     <= 1'b1;
            cur_sel  <= nsel;
            state    <= FIN;
          end
        end
        FIN: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          div_gate  <= 1'b0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= ALIGN;
        end
      endcase
    end
  end

  // Handshake flags track the state encoding exactly.
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst) req_ready == (state == IDLE));
  a_busy_ready: assert property (@(posedge clk) disable iff (!rst) busy == !req_ready);
  a_done_fin:   assert property (@(posedge clk) disable iff (!rst) done == (state == FIN));

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a done-driven scoreboard.
module tb_clk_div_ctrl;

  logic       clk, rst;
  logic [3:0] cnt;

  logic       req_valid, req_ready, div_gate, busy, done;
  logic [1:0] req_sel, div_sel, cur_sel;

  logic       hv;
  logic [1:0] hs;
  logic       h1_ready, h1_gate, h1_busy, h1_done;
  logic [1:0] h1_sel, h1_cur;
  logic       h15_ready, h15_gate, h15_busy, h15_done;
  logic [1:0] h15_sel, h15_cur;

  typedef struct {
    logic [1:0] cur;
    logic [1:0] sel;
    logic       gate;
    logic [3:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;

  clk_div_ctrl #(.CNT_W(4), .HOLD_CYCLES(2), .DEFAULT_SEL(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .div_count(cnt), .div_sel(div_sel), .div_gate(div_gate), .busy(busy), .done(done),
    .cur_sel(cur_sel));

  clk_div_ctrl #(.CNT_W(4), .HOLD_CYCLES(1), .DEFAULT_SEL(0)) u_h1 (
    .clk(clk), .rst(rst), .req_valid(hv), .req_sel(hs), .req_ready(h1_ready),
    .div_count(cnt), .div_sel(h1_sel), .div_gate(h1_gate), .busy(h1_busy), .done(h1_done),
    .cur_sel(h1_cur));

  clk_div_ctrl #(.CNT_W(4), .HOLD_CYCLES(15), .DEFAULT_SEL(0)) u_h15 (
    .clk(clk), .rst(rst), .req_valid(hv), .req_sel(hs), .req_ready(h15_ready),
    .div_count(cnt), .div_sel(h15_sel), .div_gate(h15_gate), .busy(h15_busy), .done(h15_done),
    .cur_sel(h15_cur));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running divider count shared by all instances.
  always @(posedge clk or negedge rst)
    if (!rst) cnt <= 4'd0;
    else      cnt <= cnt + 4'd1;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push_exp(input int c, input int s, input int g, input int n);
    exp_t e;
    e.cur  = 2'(c);
    e.sel  = 2'(s);
    e.gate = 1'(g);
    e.cnt  = 4'(n);
    sbq.push_back(e);
  endtask

  // Scoreboard monitor plus gate-phase watch on every instance.
  initial begin
    logic pg0, pg1, pg15, prst;
    exp_t e;
    pg0 = 1'b0; pg1 = 1'b0; pg15 = 1'b0; prst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        n_done++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_cur_sel", int'(cur_sel), int'(e.cur));
          chk("sb_div_sel", int'(div_sel), int'(e.sel));
          chk("sb_div_gate", int'(div_gate), int'(e.gate));
          chk("sb_done_cnt", int'(cnt), int'(e.cnt));
        end
      end
      if (rst && prst) begin
        if (div_gate != pg0) chk("phase_gate_h2", int'(cnt[2:0]), 0);
        if (h1_gate != pg1)  chk("phase_gate_h1", int'(cnt[2:0]), 0);
        if (h15_gate != pg15) chk("phase_gate_h15", int'(cnt[2:0]), 0);
      end
      pg0 = div_gate; pg1 = h1_gate; pg15 = h15_gate; prst = rst;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_ready", 0, 1);
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (int'(cnt) != c && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("timeout_cnt", int'(cnt), c);
  endtask

  // Called at a negedge; holds valid until ready, returns one negedge after accept.
  task automatic send(input logic [1:0] s);
    int n = 0;
    req_valid = 1'b1;
    req_sel   = s;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_send", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #30000;
    chk("watchdog", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    int d0, low, l1, l15, d1, d15;
    rst = 1'b0; req_valid = 1'b0; req_sel = 2'd0; hv = 1'b0; hs = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_div_sel", int'(div_sel), 0);
    chk("rst_gate", int'(div_gate), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_sel", int'(cur_sel), 0);

    // 1: start-up ALIGN, gate rises as count goes 7->8
    push_exp(0, 0, 1, 8);
    rst = 1'b1;
    wait_ready();
    chk("t1_idle_cnt", int'(cnt), 9);
    chk("t1_gate", int'(div_gate), 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_ndone", n_done, 1);

    // 2: /2 -> /8 accepted at count 3
    wait_cnt(3);
    push_exp(2, 2, 1, 0);
    send(2'd2);
    wait_cnt(7);
    chk("t2_gate_pre", int'(div_gate), 1);
    chk("t2_sel_pre", int'(div_sel), 0);
    @(negedge clk);
    chk("t2_gate_fall", int'(div_gate), 0);
    chk("t2_sel_sw", int'(div_sel), 2);
    low = 0;
    while (!div_gate && low < 40) begin
      low++;
      @(negedge clk);
    end
    chk("t2_low_len", low, 8);
    wait_ready();

    // 3: off, then SWITCH path back on
    push_exp(3, 3, 0, 10);
    send(2'd3);
    wait_ready();
    chk("t3_off_gate", int'(div_gate), 0);
    chk("t3_off_cur", int'(cur_sel), 3);
    chk("t3_off_cnt", int'(cnt), 11);
    push_exp(1, 1, 1, 0);
    send(2'd1);
    wait_ready();
    chk("t3_on_gate", int'(div_gate), 1);

    // 4: second request held while busy
    d0 = n_done;
    push_exp(2, 2, 1, 0);
    send(2'd2);
    push_exp(0, 0, 1, 0);
    req_valid = 1'b1;
    req_sel   = 2'd0;
    repeat (10) @(negedge clk);
    chk("t4_ready_busy", int'(req_ready), 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_cur_hold", int'(cur_sel), 1);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_accepted", int'(req_ready), 0);
    wait_ready();
    chk("t4_two_dones", n_done - d0, 2);
    chk("t4_cur", int'(cur_sel), 0);

    // 5: reset asserted in HOLD
    d0 = n_done;
    send(2'd1);
    wait_cnt(8);
    chk("t5_hold_gate", int'(div_gate), 0);
    chk("t5_hold_sel", int'(div_sel), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_sel", int'(div_sel), 0);
    chk("t5_rst_gate", int'(div_gate), 0);
    chk("t5_rst_busy", int'(busy), 1);
    chk("t5_rst_ready", int'(req_ready), 0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", n_done - d0, 0);
    push_exp(0, 0, 1, 8);
    rst = 1'b1;
    wait_ready();
    chk("t5_restart_done", n_done - d0, 1);
    chk("t5_restart_cnt", int'(cnt), 9);

    // 6: HOLD_CYCLES=1 and 15 gate-low duration
    chk("t6_h1_ready", int'(h1_ready), 1);
    chk("t6_h15_ready", int'(h15_ready), 1);
    hv = 1'b1;
    hs = 2'd2;
    @(negedge clk);
    hv = 1'b0;
    l1 = 0; l15 = 0; d1 = 0; d15 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!h1_gate)  l1++;
      if (!h15_gate) l15++;
      if (h1_done)   d1++;
      if (h15_done)  d15++;
      @(negedge clk);
    end
    chk("t6_h1_low", l1, 8);
    chk("t6_h15_low", l15, 16);
    chk("t6_h1_done", d1, 1);
    chk("t6_h15_done", d15, 1);
    chk("t6_h1_cur", int'(h1_cur), 2);
    chk("t6_h15_cur", int'(h15_cur), 2);
    chk("t6_h1_gate", int'(h1_gate), 1);
    chk("t6_h15_gate", int'(h15_gate), 1);

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
